// File: rtl/lcd_bus_monitor.sv
// Passive monitor for an HD44780-style LCD bus. It follows the writer's command
// and data traffic, keeps a shadow of both visible character lines, and answers
// status reads with {busy, AC}.
//
// Handshake: lcd_en is asynchronous. A transaction is one falling edge of the
// synchronized enable, and it uses the rs/rw/data values that went through the
// same number of synchronizer stages. Its effect lands three lcdclk edges after
// the raw enable fall. The read response is driven while the synchronized
// enable is high.
module lcd_bus_monitor #(
    parameter logic [6:0] LINE2_BASE = 7'h40,
    parameter int         NCHAR      = 16
) (
    input  logic         lcdclk,
    input  logic         reset,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic         lcd_en,
    input  logic [7:0]   lcd_data,
    output logic [7:0]   rd_data,
    output logic         rd_oe,
    output logic [127:0] line1,
    output logic [127:0] line2,
    output logic [2:0]   disp_ctl,
    output logic         cmd_valid,
    output logic [7:0]   cmd_code,
    output logic         busy,
    output logic         overrun
);

    localparam logic [6:0] NCH7  = 7'(NCHAR);
    localparam logic [7:0] BLANK = 8'h20;

    // The only FSM here is the clear engine. It has two states, so the busy
    // output already shows its full state.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Synchronizer stages. en has a third stage so that a fall can be detected.
    logic       en_s1_q, en_s2_q, en_s3_q;
    logic       rs_s1_q, rs_s2_q;
    logic       rw_s1_q, rw_s2_q;
    logic [7:0] data_s1_q, data_s2_q;

    // Architectural state
    state_t     state_q, state_d;
    logic [4:0] clr_idx_q, clr_idx_d;
    logic [6:0] ac_q, ac_d;
    logic       id_q, id_d;
    logic [2:0] disp_q, disp_d;
    logic [7:0] cmd_code_q, cmd_code_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       overrun_q, overrun_d;
    logic [7:0] line1_q [16];
    logic [7:0] line1_d [16];
    logic [7:0] line2_q [16];
    logic [7:0] line2_d [16];

    logic       en_fall;
    logic       wr_txn;
    logic [6:0] l2_off;

    assign en_fall = en_s3_q & ~en_s2_q;
    assign wr_txn  = en_fall & ~rw_s2_q;
    assign l2_off  = ac_q - LINE2_BASE;

    // Bring the bus signals into the lcdclk domain through matched stages.
    always_ff @(posedge lcdclk) begin
        if (reset) begin
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
            en_s3_q   <= 1'b0;
            rs_s1_q   <= 1'b0;
            rs_s2_q   <= 1'b0;
            rw_s1_q   <= 1'b0;
            rw_s2_q   <= 1'b0;
            data_s1_q <= 8'h00;
            data_s2_q <= 8'h00;
        end else begin
            en_s1_q   <= lcd_en;
            en_s2_q   <= en_s1_q;
            en_s3_q   <= en_s2_q;
            rs_s1_q   <= lcd_rs;
            rs_s2_q   <= rs_s1_q;
            rw_s1_q   <= lcd_rw;
            rw_s2_q   <= rw_s1_q;
            data_s1_q <= lcd_data;
            data_s2_q <= data_s2_q == data_s1_q ? data_s2_q : data_s1_q;
        end
    end

    // Next state: decode the transaction and step the clear engine.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        ac_d        = ac_q;
        id_d        = id_q;
        disp_d      = disp_q;
        cmd_code_d  = cmd_code_q;
        cmd_valid_d = 1'b0;
        overrun_d   = overrun_q;
        line1_d     = line1_q;
        line2_d     = line2_q;

        if (wr_txn) begin
            if (state_q == ST_CLEAR) begin
                // Writes that arrive during a clear, including its last cycle, are dropped.
                overrun_d = 1'b1;
            end else if (!rs_s2_q) begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = data_s2_q;
                casez (data_s2_q)
                    8'b1???????: ac_d = data_s2_q[6:0];
                    8'b00001???: disp_d = data_s2_q[2:0];
                    8'b000001??: id_d = data_s2_q[1];
                    8'b0000001?: ac_d = 7'h00;
                    8'b00000001: begin
                        state_d   = ST_CLEAR;
                        clr_idx_d = 5'd0;
                        ac_d      = 7'h00;
                        id_d      = 1'b1;
                    end
                    default: ;  // shift, function set, CGRAM address and 0x00 do nothing here
                endcase
            end else begin
                if (ac_q < NCH7) begin
                    line1_d[ac_q[3:0]] = data_s2_q;
                end else if (l2_off < NCH7) begin
                    line2_d[l2_off[3:0]] = data_s2_q;
                end
                // AC moves even when the write lands outside both lines.
                ac_d = id_q ? ac_q + 7'd1 : ac_q - 7'd1;
            end
        end

        if (state_q == ST_CLEAR) begin
            if (clr_idx_q[4]) begin
                line2_d[clr_idx_q[3:0]] = BLANK;
            end else begin
                line1_d[clr_idx_q[3:0]] = BLANK;
            end
            clr_idx_d = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) begin
                state_d = ST_IDLE;
            end
        end
    end

    // State registers. Reset wins over any clear or transaction in flight.
    always_ff @(posedge lcdclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            clr_idx_q   <= 5'd0;
            ac_q        <= 7'h00;
            id_q        <= 1'b1;
            disp_q      <= 3'b000;
            cmd_code_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                line1_q[i] <= BLANK;
                line2_q[i] <= BLANK;
            end
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            ac_q        <= ac_d;
            id_q        <= id_d;
            disp_q      <= disp_d;
            cmd_code_q  <= cmd_code_d;
            cmd_valid_q <= cmd_valid_d;
            overrun_q   <= overrun_d;
            line1_q     <= line1_d;
            line2_q     <= line2_d;
        end
    end

    // Output packing: character 0 goes in the most significant byte.
    always_comb begin
        line1 = '0;
        line2 = '0;
        for (int i = 0; i < 16; i++) begin
            line1[127 - 8*i -: 8] = line1_q[i];
            line2[127 - 8*i -: 8] = line2_q[i];
        end
    end

    // Read response: a status read returns {busy, AC}, and a data read returns zero.
    always_comb begin
        rd_oe   = en_s2_q & rw_s2_q;
        rd_data = 8'h00;
        if (rd_oe && !rs_s2_q) begin
            rd_data = {busy, ac_q};
        end
    end

    assign busy      = (state_q == ST_CLEAR);
    assign disp_ctl  = disp_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Testbench for lcd_bus_monitor. A reference model follows the LCD rules and
// uses a countdown for clear timing. Directed scenarios run first, then a
// randomized phase.
module tb_lcd_bus_monitor;

    // ---------------- clock / reset ----------------
    logic         lcdclk = 1'b0;
    logic         reset;
    logic         lcd_rs, lcd_rw, lcd_en;
    logic [7:0]   lcd_data;
    logic [7:0]   rd_data;
    logic         rd_oe;
    logic [127:0] line1, line2;
    logic [2:0]   disp_ctl;
    logic         cmd_valid;
    logic [7:0]   cmd_code;
    logic         busy;
    logic         overrun;

    always #5 lcdclk = ~lcdclk;

    lcd_bus_monitor dut (
        .lcdclk   (lcdclk),
        .reset    (reset),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data),
        .rd_data  (rd_data),
        .rd_oe    (rd_oe),
        .line1    (line1),
        .line2    (line2),
        .disp_ctl (disp_ctl),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .busy     (busy),
        .overrun  (overrun)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_l1 [16];
    logic [7:0] m_l2 [16];
    logic [6:0] m_ac;
    logic       m_id;
    logic [2:0] m_disp;
    logic [7:0] m_cmd;
    logic       m_ovr;
    int         m_busy_left;    // clear cycles still to run
    logic       busy_at_edge;   // was a clear running at the edge just passed
    logic       exp_valid;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [127:0] pack(input logic [7:0] a [16]);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = a[i];
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_l1[i] = 8'h20;
            m_l2[i] = 8'h20;
        end
        m_ac = 7'h00; m_id = 1'b1; m_disp = 3'b000; m_cmd = 8'h00;
        m_ovr = 1'b0; m_busy_left = 0; busy_at_edge = 1'b0;
    endtask

    // Apply one write that took effect at the edge just passed.
    task automatic m_apply(input logic rs, input logic [7:0] d);
        exp_valid = 1'b0;
        if (busy_at_edge) begin
            m_ovr = 1'b1;
        end else if (!rs) begin
            exp_valid = 1'b1;
            m_cmd = d;
            if (d >= 8'h80)      m_ac = d[6:0];
            else if (d >= 8'h10) ;
            else if (d >= 8'h08) m_disp = d[2:0];
            else if (d >= 8'h04) m_id = d[1];
            else if (d >= 8'h02) m_ac = 7'h00;
            else if (d == 8'h01) begin
                for (int i = 0; i < 16; i++) begin
                    m_l1[i] = 8'h20;
                    m_l2[i] = 8'h20;
                end
                m_ac = 7'h00; m_id = 1'b1; m_busy_left = 32;
            end
        end else begin
            if (m_ac < 7'd16) m_l1[m_ac[3:0]] = d;
            else if (m_ac >= 7'h40 && m_ac < 7'h50) m_l2[m_ac[3:0]] = d;
            m_ac = m_id ? m_ac + 7'd1 : m_ac - 7'd1;
        end
    endtask

    // ---------------- comparison ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Move to the next falling edge and keep the model's clear timer in step.
    task automatic tick();
        @(negedge lcdclk);
        busy_at_edge = (m_busy_left > 0);
        if (m_busy_left > 0) m_busy_left--;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(m_busy_left > 0));
        chk({tag, "_ovr"}, 128'(overrun), 128'(m_ovr));
        chk({tag, "_disp"}, 128'(disp_ctl), 128'(m_disp));
        chk({tag, "_code"}, 128'(cmd_code), 128'(m_cmd));
        if (m_busy_left == 0) begin
            chk({tag, "_line1"}, line1, pack(m_l1));
            chk({tag, "_line2"}, line2, pack(m_l2));
        end
    endtask

    task automatic do_reset();
        lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_reset();
        chk("rst_line1", line1, {16{8'h20}});
        chk("rst_line2", line2, {16{8'h20}});
        chk("rst_disp", 128'(disp_ctl), 128'(3'b000));
        chk("rst_code", 128'(cmd_code), 128'(8'h00));
        chk("rst_valid", 128'(cmd_valid), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_ovr", 128'(overrun), 128'(1'b0));
        chk("rst_oe", 128'(rd_oe), 128'(1'b0));
        chk("rst_rd", 128'(rd_data), 128'(8'h00));
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_data = d; lcd_en = 1'b1;
        tick(); tick();
        lcd_en = 1'b0;
        tick(); tick();
        chk("valid_early", 128'(cmd_valid), 128'(1'b0));
        tick();
        m_apply(rs, d);
        chk("valid_pulse", 128'(cmd_valid), 128'(exp_valid));
        check_state("wr");
        tick();
        chk("valid_drop", 128'(cmd_valid), 128'(1'b0));
    endtask

    task automatic status_read(output logic [7:0] v);
        lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_en = 1'b1;
        tick(); tick(); tick();
        v = rd_data;
        chk("st_oe", 128'(rd_oe), 128'(1'b1));
        chk("st_data", 128'(rd_data), 128'({m_busy_left > 0, m_ac}));
        lcd_en = 1'b0;
        tick(); tick(); tick();
        chk("st_oe_off", 128'(rd_oe), 128'(1'b0));
    endtask

    task automatic data_read();
        lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_en = 1'b1;
        tick(); tick(); tick();
        chk("dr_oe", 128'(rd_oe), 128'(1'b1));
        chk("dr_data", 128'(rd_data), 128'(8'h00));
        lcd_en = 1'b0;
        tick(); tick(); tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] st;
        logic [7:0] txt [4];
        logic [7:0] d;
        int         r;

        txt[0] = "T"; txt[1] = "e"; txt[2] = "x"; txt[3] = "t";
        do_reset();

        // Initialization sequence, then "Text" on line 1
        bus_write(1'b0, 8'h38);
        bus_write(1'b0, 8'h0E);
        bus_write(1'b0, 8'h06);
        bus_write(1'b0, 8'h80);
        for (int i = 0; i < 4; i++) bus_write(1'b1, txt[i]);
        chk("txt_disp", 128'(disp_ctl), 128'(3'b110));
        chk("txt_line1", 128'(line1[127:96]), 128'(32'h54657874));
        status_read(st);
        chk("txt_ac", 128'(st[6:0]), 128'(7'd4));

        // Fill line 2 with A..P
        bus_write(1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) bus_write(1'b1, 8'(8'h41 + i));
        chk("l2_fill", line2, 128'h4142434445464748494A4B4C4D4E4F50);
        status_read(st);
        chk("l2_ac", 128'(st[6:0]), 128'(7'h50));
        data_read();
        status_read(st);

        // Clear: status shows busy, then all cells are blank
        bus_write(1'b0, 8'h01);
        status_read(st);
        chk("clr_busy_bit", 128'(st[7]), 128'(1'b1));
        repeat (32) tick();
        chk("clr_done", 128'(busy), 128'(1'b0));
        chk("clr_cells", {line1, line2}, {32{8'h20}});

        // A write on the first cycle after the clear is accepted
        bus_write(1'b0, 8'h01);
        repeat (27) tick();
        bus_write(1'b1, 8'h51);
        chk("clr_after_ovr", 128'(overrun), 128'(1'b0));

        // A write on the last clear cycle is dropped
        bus_write(1'b0, 8'h01);
        repeat (26) tick();
        bus_write(1'b1, 8'h52);
        chk("clr_last_ovr", 128'(overrun), 128'(1'b1));
        chk("clr_last_cells", {line1, line2}, {32{8'h20}});
        status_read(st);

        // A data write during a clear sets overrun and changes no cell
        do_reset();
        bus_write(1'b0, 8'h01);
        bus_write(1'b1, 8'h51);
        repeat (32) tick();
        chk("ovr_flag", 128'(overrun), 128'(1'b1));
        chk("ovr_cells", {line1, line2}, {32{8'h20}});
        status_read(st);
        chk("ovr_ac", 128'(st[6:0]), 128'(7'h00));

        // Decrement mode wraps AC below zero
        bus_write(1'b0, 8'h04);
        bus_write(1'b0, 8'h80);
        bus_write(1'b1, 8'h5A);
        chk("dec_char0", 128'(line1[127:120]), 128'(8'h5A));
        status_read(st);
        chk("dec_ac", 128'(st[6:0]), 128'(7'h7F));
        bus_write(1'b1, 8'h59);
        status_read(st);
        chk("dec_ac2", 128'(st[6:0]), 128'(7'h7E));
        chk("dec_disc", line1, pack(m_l1));

        // Reset in the middle of a clear
        bus_write(1'b1, 8'h31);
        bus_write(1'b0, 8'h01);
        repeat (5) tick();
        do_reset();
        tick();
        chk("midrst_busy", 128'(busy), 128'(1'b0));

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom_range(8'h20, 8'h7E));
                bus_write(1'b1, d);
            end else begin
                r = $urandom_range(0, 11);
                case (r)
                    0:       d = 8'h01;
                    1, 2:    d = 8'(8'h80 | $urandom_range(0, 15));
                    3, 4:    d = 8'(8'hC0 | $urandom_range(0, 15));
                    5:       d = 8'(8'h04 | $urandom_range(0, 3));
                    default: d = 8'($urandom_range(2, 255));
                endcase
                bus_write(1'b0, d);
            end
            if (n % 6 == 5) status_read(st);
        end
        repeat (34) tick();
        check_state("final");
        status_read(st);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
